// File: rtl/instr_prefetch_buffer_pkg.sv
// Shared types and constants for the instruction prefetch path.
// Widths, fetch FSM states and the queued {addr, instr} entry.
package instr_prefetch_buffer_pkg;

   localparam int RISCV_ADDR_WIDTH = 32;
   localparam int RISCV_WORD_WIDTH = 32;

   typedef logic [RISCV_ADDR_WIDTH-1:0] addr_t;
   typedef logic [RISCV_WORD_WIDTH-1:0] word_t;

   localparam addr_t PC_INCR = addr_t'(4);

   typedef enum logic [1:0] {
      PF_IDLE,
      PF_REQ,
      PF_REQ_DISCARD
   } prefetch_state_e;

   typedef struct packed {
      addr_t addr;
      word_t instr;
   } fetch_entry_t;

   function automatic addr_t word_align(addr_t a);
      return {a[RISCV_ADDR_WIDTH-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/instr_prefetch_buffer_if.sv
// Instruction memory port: valid/ready request, word read data.
// master = fetch side, slave = memory side.
interface instr_prefetch_buffer_if;
   import instr_prefetch_buffer_pkg::*;

   logic       valid;
   logic       ready;
   addr_t      addr;
   word_t      wdata;
   logic [3:0] we;
   word_t      rdata;

   modport master (
      output valid, addr, wdata, we,
      input  ready, rdata
   );

   modport slave (
      input  valid, addr, wdata, we,
      output ready, rdata
   );

endinterface

// File: rtl/instr_prefetch_buffer_fifo.sv
// Generic synchronous FIFO, power-of-two depth.
// Clear beats push/pop; pop on empty is ignored.
module prefetch_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     clear,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign rdata   = mem[rd_ptr];

   // Pointer and occupancy tracking
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         unique case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Entry storage, zeroed on reset so the head reads 0 when idle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (do_push && !clear) begin
         mem[wr_ptr] <= wdata;
      end
   end

endmodule

// File: rtl/instr_prefetch_buffer.sv
// Sequential instruction prefetcher with redirect (flush) support.
// One imem request outstanding; fetched words queue for decode.
module instr_prefetch_buffer
   import instr_prefetch_buffer_pkg::*;
#(
   parameter int    DEPTH     = 2,
   parameter addr_t BOOT_ADDR = 32'h0000_0000
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush_i,
   input  addr_t                    flush_addr_i,
   output word_t                    instr_o,
   output addr_t                    instr_addr_o,
   output logic                     instr_valid_o,
   input  logic                     instr_ready_i,
   instr_prefetch_buffer_if.master  imem
);

   localparam int CW = $clog2(DEPTH);

   prefetch_state_e state;
   addr_t           pc;
   addr_t           req_addr_q;
   addr_t           flush_target;
   addr_t           issue_addr;
   logic            issue;
   logic            push;
   logic            pop;
   logic            space;
   logic            full;
   logic            empty;
   logic [CW:0]     count;
   int              count_next;
   fetch_entry_t    head;
   fetch_entry_t    entry_in;

   assign flush_target = word_align(flush_addr_i);

   // A returned word is kept only for a live, non-flushed request
   assign push     = (state == PF_REQ) && imem.ready && !flush_i;
   assign pop      = instr_valid_o && instr_ready_i;
   assign entry_in = '{addr: req_addr_q, instr: imem.rdata};

   // Room check on post-cycle occupancy so the next word always fits
   always_comb begin
      count_next = int'(count) + int'(push) - int'(pop);
      space      = (count_next < DEPTH);
   end

   // Decide whether a new request goes out this cycle, and where
   always_comb begin
      issue      = 1'b0;
      issue_addr = flush_i ? flush_target : pc;
      unique case (state)
         PF_IDLE:        issue = flush_i || space;
         PF_REQ:         issue = imem.ready && (flush_i || space);
         PF_REQ_DISCARD: issue = imem.ready;
         default:        issue = 1'b0;
      endcase
   end

   // Fetch FSM: request address, pc and discard tracking
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= PF_IDLE;
         pc         <= BOOT_ADDR;
         req_addr_q <= '0;
      end else if (issue) begin
         state      <= PF_REQ;
         req_addr_q <= issue_addr;
         pc         <= issue_addr + PC_INCR;
      end else begin
         if (flush_i) pc <= flush_target;
         if (state == PF_REQ && flush_i) begin
            state <= PF_REQ_DISCARD;
         end else if (state == PF_REQ && imem.ready) begin
            state <= PF_IDLE;
         end
      end
   end

   prefetch_fifo #(
      .WIDTH ($bits(fetch_entry_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .clear (flush_i),
      .wdata (entry_in),
      .rdata (head),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   assign imem.valid    = (state != PF_IDLE);
   assign imem.addr     = req_addr_q;
   assign imem.wdata    = '0;
   assign imem.we       = '0;

   assign instr_valid_o = !empty;
   assign instr_o       = empty ? '0 : head.instr;
   assign instr_addr_o  = empty ? '0 : head.addr;

   // Space reservation means a push never meets a full queue
   a_no_overflow: assert property (
      @(posedge clk) disable iff (!rst_n) !(push && full && !pop)
   );

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// Bench for instr_prefetch_buffer: queue-based reference model
// checked every cycle, plus directed literal expectations.
module tb_instr_prefetch_buffer;
   import instr_prefetch_buffer_pkg::*;

   localparam int DEPTH = 2;

   logic  clk = 1'b0;
   logic  rst_n;
   logic  flush;
   addr_t flush_addr;
   logic  instr_ready;
   logic  imem_ready;

   word_t instr0, instr1;
   addr_t iaddr0, iaddr1;
   logic  ivalid0, ivalid1;

   int n_cmp = 0;
   int n_bad = 0;

   instr_prefetch_buffer_if if0 ();
   instr_prefetch_buffer_if if1 ();

   function automatic word_t mem_word(addr_t a);
      return {a[15:0], a[31:16]} ^ 32'hC0DE_0013;
   endfunction

   assign if0.ready = imem_ready;
   assign if0.rdata = mem_word(if0.addr);
   assign if1.ready = imem_ready;
   assign if1.rdata = mem_word(if1.addr);

   instr_prefetch_buffer #(.DEPTH(DEPTH), .BOOT_ADDR(32'h0000_0000)) u0 (
      .clk           (clk),
      .rst_n         (rst_n),
      .flush_i       (flush),
      .flush_addr_i  (flush_addr),
      .instr_o       (instr0),
      .instr_addr_o  (iaddr0),
      .instr_valid_o (ivalid0),
      .instr_ready_i (instr_ready),
      .imem          (if0)
   );

   instr_prefetch_buffer #(.DEPTH(DEPTH), .BOOT_ADDR(32'hFFFF_FFF8)) u1 (
      .clk           (clk),
      .rst_n         (rst_n),
      .flush_i       (flush),
      .flush_addr_i  (flush_addr),
      .instr_o       (instr1),
      .instr_addr_o  (iaddr1),
      .instr_valid_o (ivalid1),
      .instr_ready_i (instr_ready),
      .imem          (if1)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model for u0: fetch-ahead with a queue of {addr, word}
   logic [63:0] mq[$];
   bit          m_busy;
   bit          m_drop;
   addr_t       m_pc;
   addr_t       m_raddr;

   task automatic model_step();
      bit    acc;
      bit    can_issue;
      addr_t tgt;
      acc       = m_busy && imem_ready;
      can_issue = !m_busy || acc;
      if (flush) begin
         mq.delete();
         tgt = {flush_addr[31:2], 2'b00};
         if (can_issue) begin
            m_raddr = tgt;
            m_pc    = tgt + 32'd4;
            m_busy  = 1'b1;
            m_drop  = 1'b0;
         end else begin
            m_pc   = tgt;
            m_drop = 1'b1;
         end
      end else begin
         if (mq.size() > 0 && instr_ready) void'(mq.pop_front());
         if (acc && !m_drop) mq.push_back({m_raddr, mem_word(m_raddr)});
         if (can_issue) begin
            if (mq.size() < DEPTH) begin
               m_raddr = m_pc;
               m_pc    = m_pc + 32'd4;
               m_busy  = 1'b1;
               m_drop  = 1'b0;
            end else begin
               m_busy = 1'b0;
            end
         end
      end
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mq.delete();
         m_busy  = 1'b0;
         m_drop  = 1'b0;
         m_pc    = 32'h0;
         m_raddr = 32'h0;
      end else begin
         model_step();
      end
   end

   // Per-cycle comparison of u0 against the model
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         check("imem_valid", {31'b0, if0.valid}, {31'b0, m_busy});
         if (m_busy) check("imem_addr", if0.addr, m_raddr);
         check("instr_valid", {31'b0, ivalid0}, {31'b0, mq.size() > 0});
         if (mq.size() > 0) begin
            check("instr_addr", iaddr0, mq[0][63:32]);
            check("instr", instr0, mq[0][31:0]);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      check("rst_imem_valid", {31'b0, if0.valid}, 32'h0);
      check("rst_imem_addr", if0.addr, 32'h0);
      check("rst_instr_valid", {31'b0, ivalid0}, 32'h0);
      check("rst_instr", instr0, 32'h0);
      check("rst_instr_addr", iaddr0, 32'h0);
      check("rst_u1_imem_valid", {31'b0, if1.valid}, 32'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      flush       = 1'b0;
      flush_addr  = 32'h0;
      instr_ready = 1'b1;
      imem_ready  = 1'b1;

      // Streaming from boot; u1 shows the address wrap
      do_reset();
      tick();
      check("A1_imem_valid", {31'b0, if0.valid}, 32'h1);
      check("A1_imem_addr", if0.addr, 32'h0);
      check("A1_u1_addr", if1.addr, 32'hFFFF_FFF8);
      tick();
      check("A2_imem_addr", if0.addr, 32'h4);
      check("A2_instr_valid", {31'b0, ivalid0}, 32'h1);
      check("A2_instr_addr", iaddr0, 32'h0);
      check("A2_instr", instr0, mem_word(32'h0));
      check("A2_u1_addr", if1.addr, 32'hFFFF_FFFC);
      check("A2_u1_instr_addr", iaddr1, 32'hFFFF_FFF8);
      tick();
      check("A3_imem_addr", if0.addr, 32'h8);
      check("A3_instr_addr", iaddr0, 32'h4);
      check("A3_u1_addr", if1.addr, 32'h0);
      repeat (8) tick();

      // Decoder stalled: two words queue, fetch stops, then resumes
      instr_ready = 1'b0;
      do_reset();
      repeat (3) tick();
      check("B3_imem_valid", {31'b0, if0.valid}, 32'h0);
      check("B3_instr_addr", iaddr0, 32'h0);
      tick();
      check("B4_imem_valid", {31'b0, if0.valid}, 32'h0);
      check("B4_instr", instr0, mem_word(32'h0));
      instr_ready = 1'b1;
      tick();
      check("B5_imem_valid", {31'b0, if0.valid}, 32'h1);
      check("B5_imem_addr", if0.addr, 32'h8);
      check("B5_instr_addr", iaddr0, 32'h4);

      // Flush while the 0x8 request is stalled
      imem_ready = 1'b0;
      flush      = 1'b1;
      flush_addr = 32'h100;
      tick();
      flush = 1'b0;
      check("C1_imem_addr", if0.addr, 32'h8);
      check("C1_instr_valid", {31'b0, ivalid0}, 32'h0);
      repeat (2) tick();
      check("C3_imem_addr", if0.addr, 32'h8);
      check("C3_imem_valid", {31'b0, if0.valid}, 32'h1);
      imem_ready = 1'b1;
      tick();
      check("C4_imem_addr", if0.addr, 32'h100);
      check("C4_instr_valid", {31'b0, ivalid0}, 32'h0);
      tick();
      check("C5_instr_addr", iaddr0, 32'h100);
      check("C5_imem_addr", if0.addr, 32'h104);

      // Flush coinciding with a completed 0x10 fetch, misaligned target
      do_reset();
      repeat (5) tick();
      check("D5_imem_addr", if0.addr, 32'h10);
      flush      = 1'b1;
      flush_addr = 32'h203;
      tick();
      flush = 1'b0;
      check("D6_imem_addr", if0.addr, 32'h200);
      check("D6_instr_valid", {31'b0, ivalid0}, 32'h0);
      tick();
      check("D7_instr_addr", iaddr0, 32'h200);

      // Asynchronous reset in the middle of a request
      instr_ready = 1'b0;
      do_reset();
      repeat (2) tick();
      #2;
      do_reset();
      instr_ready = 1'b1;
      tick();
      check("E1_imem_addr", if0.addr, 32'h0);
      check("E1_imem_valid", {31'b0, if0.valid}, 32'h1);

      // Mixed stalls and redirects, checked against the model
      for (int i = 0; i < 300; i++) begin
         imem_ready  = ($urandom_range(0, 3) != 0);
         instr_ready = ($urandom_range(0, 3) != 0);
         flush       = ($urandom_range(0, 15) == 0);
         flush_addr  = $urandom;
         tick();
      end
      flush = 1'b0;
      repeat (4) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
